// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;
    localparam int DIV_CW = $clog2(DIV_DW + 1);

endpackage

// File: rtl/cla_sub.sv
// W-bit carry-lookahead subtractor: diff = a + ~b + 1, borrow = no carry out.
module cla_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;
    logic         acc;
    logic         term;

    assign gen  = a & ~b;
    assign prop = a ^ ~b;

    // Each carry is expanded as a flat sum of generate terms; carry-in is 1.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        acc      = 1'b0;
        term     = 1'b1;
        for (int i = 0; i < W; i++) begin
            acc  = 1'b0;
            term = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc  = acc | (term & gen[j]);
                term = term & prop[j];
            end
            carry[i+1] = acc | term;
        end
    end

    assign diff   = prop ^ carry[W-1:0];
    assign borrow = ~carry[W];

endmodule

// File: rtl/div8_seq.sv
// Sequential shift-subtract divider, one quotient bit per clock, valid/ready in and out.
module div8_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready/out_valid decode the state register only, never the inputs.
    div_state_t    state_q, state_d;
    logic [DW-1:0] q_sr_q, q_sr_d;
    logic [VW-1:0] d_q, d_d;
    logic [VW:0]   p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   s;
    logic [VW:0]   t;
    logic          borrow;
    logic [VW:0]   p_next;
    logic [DW-1:0] q_next;

    assign s      = (VW+1)'({p_q, q_sr_q[DW-1]});
    assign p_next = borrow ? s : t;
    assign q_next = DW'({q_sr_q, ~borrow});

    cla_sub #(.W(VW + 1)) u_sub (
        .a      (s),
        .b      ({1'b0, d_q}),
        .diff   (t),
        .borrow (borrow)
    );

    always_comb begin
        state_d     = state_q;
        q_sr_d      = q_sr_q;
        d_d         = d_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    q_sr_d = dividend;
                    d_d    = divisor;
                    p_d    = '0;
                    cnt_d  = CW'(DW);
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[VW-1:0];
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                q_sr_d = q_next;
                p_d    = p_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    quotient_d  = q_next;
                    remainder_d = p_next[VW-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_sr_q      <= '0;
            d_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_sr_q      <= q_sr_d;
            d_q         <= d_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Directed and swept checks of div8_seq against hand-computed and golden quotient/remainder.
module tb_div8_seq;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    div8_seq #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_quotient"}, 32'(quotient), 0);
        check({tag, "_remainder"}, 32'(remainder), 0);
        check({tag, "_dbz"}, 32'(div_by_zero), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction: accept, wait for result, hold for 'hold' cycles, release.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er,
                          input logic ez, input int hold, input bit junk, input string tag);
        int n;
        int lat;
        int busy_bad;
        int hold_bad;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_before"}, 32'(in_ready), 1);
        if (!in_ready) begin
            do_reset();
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (!out_valid && lat < DW + 4) begin
            if (in_ready) busy_bad++;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = DW'($urandom);
                divisor  = VW'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), (b == '0) ? 0 : DW);
        check({tag, "_busy_ready"}, 32'(busy_bad), 0);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
            @(negedge clk);
            if (!out_valid || in_ready || quotient !== eq || remainder !== er || div_by_zero !== ez)
                hold_bad++;
        end
        in_valid = 1'b0;
        if (hold > 0) check({tag, "_hold_stable"}, 32'(hold_bad), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_ready"}, 32'(in_ready), 1);
        check({tag, "_release_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // directed vectors, expected values computed by hand
        run_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 0, 1'b0, "d200_7");
        run_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 0, 1'b1, "d255_1");
        run_op(8'd7,   4'd9,  8'd0,   4'd7, 1'b0, 0, 1'b1, "d7_9");
        run_op(8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 0, 1'b0, "d15_15");
        run_op(8'd100, 4'd0,  8'd255, 4'd4, 1'b1, 0, 1'b0, "d100_0");
        run_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 5, 1'b1, "bp200_7");
        run_op(8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 1, 1'b0, "d0_5");
        run_op(8'd29,  4'd0,  8'd255, 4'd13, 1'b1, 2, 1'b1, "d29_0");

        // reset three iterations into a run, with the previous result still registered
        run_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 0, 1'b0, "pre_abort");
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("abort_idle");
        run_op(8'd50, 4'd6, 8'd8, 4'd2, 1'b0, 0, 1'b0, "after_abort");

        // full sweep of nonzero divisors with random gaps, junk inputs and backpressure
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                run_op(DW'(a), VW'(b), DW'(a / b), VW'(a % b), 1'b0,
                       $urandom_range(0, 2), 1'b1, "sweep");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
